// File: rtl/cordic_core.sv
// cordic_core: iterative 16-micro-rotation CORDIC engine, signed Q2.16 datapath.
// Performs two chained micro-rotations per clock using the atan table pair
// selected by `stage`. Rotation mode drives z to 0; vectoring mode drives y to 0.
// Build option: define CORDIC_QUADRANT_EN to pre-rotate by +/-pi/2 at load,
// extending the convergence range to the full circle at no latency cost.
module cordic_core #(
   parameter int WIDTH = 18,
   parameter int ITERS = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] x_in,
   input  logic [WIDTH-1:0] y_in,
   input  logic [WIDTH-1:0] z_in,
   output logic [3:0]       stage,
   input  logic [WIDTH-1:0] atan0,
   input  logic [WIDTH-1:0] atan1,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] x_out,
   output logic [WIDTH-1:0] y_out,
   output logic [WIDTH-1:0] z_out
);

   localparam int HALF = ITERS / 2;
   localparam int KW   = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(HALF - 1);

`ifdef CORDIC_QUADRANT_EN
   localparam logic signed [WIDTH-1:0] HALF_PI = WIDTH'(18'h1921F);
`endif

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   typedef struct packed {
      logic [WIDTH-1:0] x;
      logic [WIDTH-1:0] y;
      logic [WIDTH-1:0] z;
   } vec_t;

   state_t        state;
   state_t        state_next;
   vec_t          acc;
   vec_t          ld;
   vec_t          mid;
   vec_t          nxt;
   logic          mode_r;
   logic [KW-1:0] k;

   // One micro-rotation: direction from the sign of z (rotation) or y (vectoring),
   // arithmetic shifts and wrapping adds with no saturation.
   function automatic vec_t micro_rot(input vec_t v, input logic vmode,
                                      input logic [KW:0] sh, input logic [WIDTH-1:0] a);
      vec_t             r;
      logic             d;
      logic [WIDTH-1:0] xs;
      logic [WIDTH-1:0] ys;
      d   = vmode ? v.y[WIDTH-1] : ~v.z[WIDTH-1];
      xs  = $signed(v.x) >>> sh;
      ys  = $signed(v.y) >>> sh;
      r.x = d ? (v.x - ys) : (v.x + ys);
      r.y = d ? (v.y + xs) : (v.y - xs);
      r.z = d ? (v.z - a)  : (v.z + a);
      return r;
   endfunction

   // Operand load value, optionally pre-rotated into the convergent half-plane.
   always_comb begin
      ld.x = x_in;
      ld.y = y_in;
      ld.z = z_in;
`ifdef CORDIC_QUADRANT_EN
      if (!mode) begin
         if ($signed(z_in) > HALF_PI) begin
            ld.x = -y_in;
            ld.y = x_in;
            ld.z = z_in - HALF_PI;
         end else if ($signed(z_in) < -HALF_PI) begin
            ld.x = y_in;
            ld.y = -x_in;
            ld.z = z_in + HALF_PI;
         end
      end else if (x_in[WIDTH-1]) begin
         if (!y_in[WIDTH-1]) begin
            ld.x = y_in;
            ld.y = -x_in;
            ld.z = z_in + HALF_PI;
         end else begin
            ld.x = -y_in;
            ld.y = x_in;
            ld.z = z_in - HALF_PI;
         end
      end
`endif
   end

   // Two chained micro-rotations per cycle, indices 2k and 2k+1.
   always_comb begin
      mid = micro_rot(acc, mode_r, {k, 1'b0}, atan0);
      nxt = micro_rot(mid, mode_r, {k, 1'b1}, atan1);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic and status outputs; stage is only nonzero while running.
   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      stage      = 4'd0;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_next = S_RUN;
            end
         end
         S_RUN: begin
            busy  = 1'b1;
            stage = 4'({k, 1'b0});
            if (k == K_LAST) begin
               state_next = S_DONE;
            end
         end
         S_DONE: begin
            busy       = 1'b1;
            done       = 1'b1;
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Datapath: load on start, iterate while running, publish results on the
   // final iteration so they are valid in the done cycle and held afterwards.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc    <= '0;
         mode_r <= 1'b0;
         k      <= '0;
         x_out  <= '0;
         y_out  <= '0;
         z_out  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  acc    <= ld;
                  mode_r <= mode;
                  k      <= '0;
               end
            end
            S_RUN: begin
               acc <= nxt;
               k   <= k + KW'(1);
               if (k == K_LAST) begin
                  x_out <= nxt.x;
                  y_out <= nxt.y;
                  z_out <= nxt.z;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cordic_core.sv
// tb_cordic_core: self-checking bench for cordic_core.
// Directed vectors are checked against ideal trig values (+/-8 LSB) and every
// operation against an exact integer model of the micro-rotation sequence.
// Honours CORDIC_QUADRANT_EN for both the reference model and the corner cases.
module tb_cordic_core;

   localparam int ITERS = 16;
   localparam int LAT   = ITERS / 2 + 1;
   localparam int ATAN [16] = '{51472, 30386, 16055, 8150, 4091, 2047, 1024, 512,
                                256, 128, 64, 32, 16, 8, 4, 2};
`ifdef CORDIC_QUADRANT_EN
   localparam int HALF_PI = 102943;
`endif

   typedef struct {
      bit m;
      int x;
      int y;
      int z;
      int ex;
      int ey;
      int ez;
   } stim_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        mode;
   logic [17:0] x_in;
   logic [17:0] y_in;
   logic [17:0] z_in;
   logic [3:0]  stage;
   logic [17:0] atan0;
   logic [17:0] atan1;
   logic        busy;
   logic        done;
   logic [17:0] x_out;
   logic [17:0] y_out;
   logic [17:0] z_out;

   int n_checks = 0;
   int n_fail   = 0;
   int stage_log[$];
   stim_t vecs[5];

   cordic_core dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .mode  (mode),
      .x_in  (x_in),
      .y_in  (y_in),
      .z_in  (z_in),
      .stage (stage),
      .atan0 (atan0),
      .atan1 (atan1),
      .busy  (busy),
      .done  (done),
      .x_out (x_out),
      .y_out (y_out),
      .z_out (z_out)
   );

   always #5 clk = ~clk;

   // Arctangent table feeding the engine.
   assign atan0 = 18'(ATAN[stage]);
   assign atan1 = 18'(ATAN[stage + 4'd1]);

   function automatic int sx(input logic [17:0] v);
      logic signed [17:0] t;
      t = v;
      return int'(t);
   endfunction

   function automatic int wrap(input int v);
      return sx(v[17:0]);
   endfunction

   // Reference: optional quadrant fold, then ITERS sequential micro-rotations
   // with 18-bit wraparound after every operation.
   function automatic void model(input bit m, input int xi, input int yi, input int zi,
                                 output int xo, output int yo, output int zo);
      int x;
      int y;
      int z;
      int nx;
      int ny;
      int nz;
      bit d;
      x = wrap(xi);
      y = wrap(yi);
      z = wrap(zi);
`ifdef CORDIC_QUADRANT_EN
      nx = x;
      ny = y;
      nz = z;
      if (!m && z > HALF_PI) begin
         nx = -y; ny = x; nz = z - HALF_PI;
      end else if (!m && z < -HALF_PI) begin
         nx = y; ny = -x; nz = z + HALF_PI;
      end else if (m && x < 0) begin
         if (y >= 0) begin
            nx = y; ny = -x; nz = z + HALF_PI;
         end else begin
            nx = -y; ny = x; nz = z - HALF_PI;
         end
      end
      x = wrap(nx);
      y = wrap(ny);
      z = wrap(nz);
`endif
      for (int i = 0; i < ITERS; i++) begin
         d = m ? (y < 0) : (z >= 0);
         if (d) begin
            nx = x - (y >>> i); ny = y + (x >>> i); nz = z - ATAN[i];
         end else begin
            nx = x + (y >>> i); ny = y - (x >>> i); nz = z + ATAN[i];
         end
         x = wrap(nx);
         y = wrap(ny);
         z = wrap(nz);
      end
      xo = x;
      yo = y;
      zo = z;
   endfunction

   task automatic check_output(input string name, input int act, input int exp, input int tol);
      int diff;
      diff = act - exp;
      if (diff < 0) diff = -diff;
      n_checks++;
      if (diff > tol) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d (tolerance %0d)", name, act, exp, tol);
      end
   endtask

   // Present one operation, wait (bounded) for done, return results and latency
   // in clock periods counted from the period in which start was presented.
   task automatic apply_stimulus(input bit m, input int xi, input int yi, input int zi,
                                 output int gx, output int gy, output int gz, output int lat);
      int cnt;
      @(negedge clk);
      mode  = m;
      x_in  = 18'(xi);
      y_in  = 18'(yi);
      z_in  = 18'(zi);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      stage_log.delete();
      cnt = 0;
      while (!done && cnt < 20) begin
         if (busy) stage_log.push_back(int'(stage));
         @(negedge clk);
         cnt++;
      end
      lat = cnt + 1;
      gx  = sx(x_out);
      gy  = sx(y_out);
      gz  = sx(z_out);
   endtask

   task automatic check_exact(input string tag, input bit m, input int xi, input int yi,
                              input int zi, input int gx, input int gy, input int gz);
      int ex;
      int ey;
      int ez;
      model(m, xi, yi, zi, ex, ey, ez);
      check_output({tag, "_x_exact"}, gx, ex, 0);
      check_output({tag, "_y_exact"}, gy, ey, 0);
      check_output({tag, "_z_exact"}, gz, ez, 0);
   endtask

   // Watchdog so a stuck run still terminates.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int gx;
      int gy;
      int gz;
      int lat;
      int done_count;
      int held;
      bit rm;
      int rx;
      int ry;
      int rz;

      vecs[0] = '{1'b0, 39797, 0, 51472, 46341, 46341, 0};
      vecs[1] = '{1'b0, 39797, 0, 0, 65536, 0, 0};
      vecs[2] = '{1'b1, 32768, 32768, 0, 76313, 0, 51472};
      vecs[3] = '{1'b0, 39797, 0, -51472, 46341, -46341, 0};
      vecs[4] = '{1'b1, 32768, -32768, 0, 76313, 0, -51472};

      rst   = 1'b1;
      start = 1'b0;
      mode  = 1'b0;
      x_in  = '0;
      y_in  = '0;
      z_in  = '0;
      repeat (3) @(negedge clk);
      check_output("reset_busy", int'(busy), 0, 0);
      check_output("reset_done", int'(done), 0, 0);
      check_output("reset_stage", int'(stage), 0, 0);
      check_output("reset_x_out", sx(x_out), 0, 0);
      check_output("reset_y_out", sx(y_out), 0, 0);
      check_output("reset_z_out", sx(z_out), 0, 0);
      rst = 1'b0;

      $display("[TB] directed vectors");
      for (int i = 0; i < 5; i++) begin
         apply_stimulus(vecs[i].m, vecs[i].x, vecs[i].y, vecs[i].z, gx, gy, gz, lat);
         check_output($sformatf("vec%0d_latency", i), lat, LAT, 0);
         check_output($sformatf("vec%0d_x", i), gx, vecs[i].ex, 8);
         check_output($sformatf("vec%0d_y", i), gy, vecs[i].ey, 8);
         check_output($sformatf("vec%0d_z", i), gz, vecs[i].ez, 8);
         check_exact($sformatf("vec%0d", i), vecs[i].m, vecs[i].x, vecs[i].y, vecs[i].z,
                     gx, gy, gz);
      end

      $display("[TB] stage sequence and done pulse width");
      apply_stimulus(1'b0, 39797, 0, 0, gx, gy, gz, lat);
      check_output("stage_count", stage_log.size(), ITERS / 2, 0);
      for (int i = 0; i < stage_log.size() && i < ITERS / 2; i++) begin
         check_output($sformatf("stage_%0d", i), stage_log[i], 2 * i, 0);
      end
      held = gx;
      @(negedge clk);
      check_output("done_one_cycle", int'(done), 0, 0);
      check_output("busy_after_done", int'(busy), 0, 0);
      check_output("x_out_held", sx(x_out), held, 0);

      $display("[TB] start while running is ignored");
      @(negedge clk);
      mode  = 1'b0;
      x_in  = 18'(39797);
      y_in  = 18'(0);
      z_in  = 18'(51472);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      mode  = 1'b1;
      x_in  = 18'(20000);
      y_in  = 18'(-10000);
      z_in  = 18'(5000);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      done_count = 0;
      for (int i = 0; i < 20; i++) begin
         if (done) done_count++;
         @(negedge clk);
      end
      check_output("ignored_start_done_count", done_count, 1, 0);
      check_exact("ignored_start", 1'b0, 39797, 0, 51472, sx(x_out), sx(y_out), sx(z_out));

      $display("[TB] reset during run");
      @(negedge clk);
      mode  = 1'b0;
      x_in  = 18'(39797);
      y_in  = 18'(0);
      z_in  = 18'(0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_output("midrst_busy", int'(busy), 0, 0);
      check_output("midrst_done", int'(done), 0, 0);
      check_output("midrst_x_out", sx(x_out), 0, 0);
      check_output("midrst_y_out", sx(y_out), 0, 0);
      check_output("midrst_z_out", sx(z_out), 0, 0);
      rst = 1'b0;
      done_count = 0;
      for (int i = 0; i < 15; i++) begin
         if (done) done_count++;
         @(negedge clk);
      end
      check_output("midrst_no_done", done_count, 0, 0);
      apply_stimulus(1'b1, 30000, 12000, 0, gx, gy, gz, lat);
      check_output("after_rst_latency", lat, LAT, 0);
      check_exact("after_rst", 1'b1, 30000, 12000, 0, gx, gy, gz);

      $display("[TB] quadrant corner cases");
      apply_stimulus(1'b1, -16384, 65536, 0, gx, gy, gz, lat);
`ifdef CORDIC_QUADRANT_EN
      check_output("quad_vec_latency", lat, LAT, 0);
      check_output("quad_vec_z", gz, 119000, 8);
      check_exact("quad_vec", 1'b1, -16384, 65536, 0, gx, gy, gz);
`else
      check_output("quad_vec_done", lat, LAT, 0);
      check_output("quad_vec_no_x", int'($isunknown({x_out, y_out, z_out})), 0, 0);
`endif
      apply_stimulus(1'b0, 39797, 0, 114688, gx, gy, gz, lat);
`ifdef CORDIC_QUADRANT_EN
      check_output("quad_rot_latency", lat, LAT, 0);
      check_output("quad_rot_x", gx, -11678, 8);
      check_output("quad_rot_y", gy, 64487, 8);
      check_exact("quad_rot", 1'b0, 39797, 0, 114688, gx, gy, gz);
`else
      check_output("quad_rot_done", lat, LAT, 0);
      check_output("quad_rot_no_x", int'($isunknown({x_out, y_out, z_out})), 0, 0);
`endif

      $display("[TB] randomized operations");
      for (int n = 0; n < 40; n++) begin
         rm = 1'($urandom_range(0, 1));
         ry = int'($urandom_range(0, 104856)) - 52428;
         if (rm) begin
            rx = int'($urandom_range(1000, 52428));
`ifdef CORDIC_QUADRANT_EN
            if ($urandom_range(0, 1) == 1) rx = -rx;
`endif
            rz = int'($urandom_range(0, 20000)) - 10000;
         end else begin
            rx = int'($urandom_range(0, 104856)) - 52428;
            rz = int'($urandom_range(0, 220000)) - 110000;
         end
         apply_stimulus(rm, rx, ry, rz, gx, gy, gz, lat);
         check_output($sformatf("rand%0d_latency", n), lat, LAT, 0);
         check_exact($sformatf("rand%0d", n), rm, rx, ry, rz, gx, gy, gz);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
